ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter for the eLC-3. It sends one command byte to the keyboard (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) using the PS/2 host-to-device protocol, and drives the open-drain clock and data lines through pull-low enables. It sits beside the keyboard receiver on the same PS2_KBCLK/PS2_KBDAT pins and holds off that receiver while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the keyboard transmitter and receiver:
// transmitter state encoding, well-known command bytes, the device ACK byte
// and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_INHIBIT   = 3'd1,
        TX_REQ       = 3'd2,
        TX_DATA      = 3'd3,
        TX_PARITY    = 3'd4,
        TX_STOP      = 3'd5,
        TX_WAIT_IDLE = 3'd6
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Odd parity bit: makes the count of ones over data plus parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins plus a
// falling-edge detector on the synchronized clock. Shared with the receiver.
// Registers reset to 1 (idle bus level) so reset never fakes an edge.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps_clk_i,
    input  logic ps_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fe_o
);

    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic data_meta_q;
    logic data_sync_q;

    // Resynchronize both pins and keep the previous synced clock for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_sync_o  = clk_sync_q;
    assign data_sync_o = data_sync_q;
    assign clk_fe_o    = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte: inhibit the
// clock, request-to-send, then data/parity/stop clocked out on device
// falling edges, and finally checks the device ACK.
// Optional feature macro: PS2_TX_TIMEOUT_EN -- aborts with Error when the
// device stops clocking for TIMEOUT_CYCLES once the request has been made.
// All outputs are registered; they are computed from the next state.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] TxData,
    input  logic       TxStart,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic       RxInhibit,
    input  logic       psClkIn,
    input  logic       psDataIn,
    output logic       psClkOe,
    output logic       psDataOe
);

    // One counter serves the inhibit interval and, when enabled, the
    // edge timeout; it is sized for the larger of the two.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       shift_q, shift_d;     // {parity, data}; LSB is the bit on the line
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_sync_s;
    logic data_sync_s;
    logic clk_fe_s;

    ps2_line_sync u_line_sync (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .ps_clk_i   (psClkIn),
        .ps_data_i  (psDataIn),
        .clk_sync_o (clk_sync_s),
        .data_sync_o(data_sync_s),
        .clk_fe_o   (clk_fe_s)
    );

    // Next-state logic: frame sequencing, shift register and counters
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (TxStart) begin
                    shift_d  = {ps2_odd_parity(TxData), TxData};
                    cnt_d    = CNT_ZERO;
                    bitcnt_d = 4'd0;
                    state_d  = TX_INHIBIT;
                end else begin
                    state_d  = TX_IDLE;
                end
            end
            TX_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = TX_REQ;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            TX_REQ: begin
                // Start bit is on the line; first device edge asks for data bit 0.
                if (clk_fe_s) begin
                    bitcnt_d = 4'd1;
                    state_d  = TX_DATA;
                end else begin
                    state_d  = TX_REQ;
                end
            end
            TX_DATA: begin
                if (clk_fe_s) begin
                    shift_d  = {1'b0, shift_q[8:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd8) begin
                        state_d = TX_PARITY;    // this edge put parity on the line
                    end else begin
                        state_d = TX_DATA;
                    end
                end else begin
                    state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (clk_fe_s) begin
                    state_d = TX_STOP;
                end else begin
                    state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (clk_fe_s) begin
                    if (!data_sync_s) begin
                        state_d = TX_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    state_d = TX_STOP;
                end
            end
            TX_WAIT_IDLE: begin
                if (clk_sync_s && data_sync_s) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_WAIT_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Edge watchdog: any device falling edge restarts it; expiry wins
        // over a simultaneous Done so the two pulses stay exclusive.
        if (state_q inside {TX_REQ, TX_DATA, TX_PARITY, TX_STOP, TX_WAIT_IDLE}) begin
            if (clk_fe_s) begin
                cnt_d = CNT_ZERO;
            end else if (cnt_q == TIMEOUT_LAST) begin
                cnt_d   = CNT_ZERO;
                done_d  = 1'b0;
                error_d = 1'b1;
                state_d = TX_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_d;
        end
`endif
    end

    // Line drive and status derived from the next state so outputs are registered
    always_comb begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = (state_d != TX_IDLE);

        case (state_d)
            TX_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
            TX_INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = (cnt_d == INHIBIT_LAST);
            end
            TX_REQ: begin
                data_oe_d = 1'b1;
            end
            TX_DATA, TX_PARITY: begin
                data_oe_d = ~shift_d[0];
            end
            TX_STOP, TX_WAIT_IDLE: begin
                data_oe_d = 1'b0;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= CNT_ZERO;
            shift_q   <= 9'd0;
            bitcnt_q  <= 4'd0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign Busy      = busy_q;
    assign RxInhibit = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign psClkOe   = clk_oe_q;
    assign psDataOe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device
// (40-Clk clock period, samples data on its rising clock edges).
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] TxData;
    logic       TxStart;
    logic       Busy, Done, Error, RxInhibit, psClkOe, psDataOe;
    logic       dev_clk_low, dev_dat_low;

    // Open-drain bus: either side may pull low
    wire ps_clk_pin = ~(psClkOe | dev_clk_low);
    wire ps_dat_pin = ~(psDataOe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .TxData(TxData), .TxStart(TxStart),
        .Busy(Busy), .Done(Done), .Error(Error), .RxInhibit(RxInhibit),
        .psClkIn(ps_clk_pin), .psDataIn(ps_dat_pin),
        .psClkOe(psClkOe), .psDataOe(psDataOe)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int rxinh_bad = 0;
    logic prev_err = 1'b0;
    logic [1:0] oe_after_err = 2'b11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling Clk edge and log pulse activity
    task automatic tick();
        @(negedge Clk);
        if (Done === 1'b1) done_cnt++;
        if (Error === 1'b1) err_cnt++;
        if (Done === 1'b1 && Error === 1'b1) both_cnt++;
        if (RxInhibit !== Busy) rxinh_bad++;
        if (prev_err) oe_after_err = {psClkOe, psDataOe};
        prev_err = (Error === 1'b1);
    endtask

    // Reference frame as the device sees it on its rising edges:
    // [7:0] data LSB first, [8] odd parity, [9] stop, [10] ACK slot
    function automatic logic [10:0] frame_model(input logic [7:0] b, input bit ack);
        logic [10:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8]  = (($countones(b) % 2) == 0);
        f[9]  = 1'b1;
        f[10] = ack ? 1'b0 : 1'b1;
        return f;
    endfunction

    // Request a transfer and check the inhibit/request-to-send phase
    task automatic start_tx(input logic [7:0] b, input string tag);
        int n_clk;
        int n_both;
        TxData  = b;
        TxStart = 1'b1;
        tick();
        TxStart = 1'b0;
        check({tag, "_busy_clkoe_rise"}, {30'd0, Busy, psClkOe}, 32'd3);
        n_clk  = 0;
        n_both = 0;
        for (int k = 0; k < 100 && psClkOe === 1'b1; k++) begin
            n_clk++;
            if (psDataOe === 1'b1) n_both++;
            tick();
        end
        check({tag, "_inhibit_len"}, 32'(n_clk), 32'(INH));
        check({tag, "_data_before_clk"}, 32'(n_both), 32'd1);
        check({tag, "_req_lines"}, {30'd0, psClkOe, psDataOe}, 32'd1);
    endtask

    // Behavioural device: clocks out 11 pulses, optional ACK, optional
    // host-side TxStart injection or Reset at a given pulse
    task automatic dev_frame(input bit ack, input int inject_at, input int reset_at,
                             output logic [10:0] bits, output int d2, output int d3,
                             output int lat, output int busy_low, output logic busy_at_done);
        int w;
        bits = 11'd0; d2 = -1; d3 = -1; lat = -1; busy_low = 0; busy_at_done = 1'bx;
        w = 0;
        while (!(psClkOe === 1'b0 && psDataOe === 1'b1) && w < 200) begin
            tick();
            w++;
        end
        check("dev_req_wait", {31'd0, (w < 200)}, 32'd1);
        repeat (5) tick();
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack) dev_dat_low = 1'b1;
            repeat (5) tick();
            dev_clk_low = 1'b1;
            for (int t = 1; t <= HALF; t++) begin
                tick();
                if (i == 0 && t == 2) d2 = int'(ps_dat_pin);
                if (i == 0 && t == 3) d3 = int'(ps_dat_pin);
                if (i == inject_at && t == 5) begin
                    TxData  = 8'h00;
                    TxStart = 1'b1;
                end
                if (i == inject_at && t == 6) TxStart = 1'b0;
                if (i == reset_at && t == 10) Reset = 1'b1;
                if (i == reset_at && t == 11) begin
                    Reset = 1'b0;
                    check("reset_mid_frame",
                          {27'd0, psClkOe, psDataOe, Busy, Done, Error}, 32'd0);
                    dev_clk_low = 1'b0;
                    return;
                end
            end
            bits[i] = ps_dat_pin;
            if (i < 10 && Busy !== 1'b1) busy_low++;
            dev_clk_low = 1'b0;
            if (i == 10) dev_dat_low = 1'b0;
            if (i == 10 && ack) begin
                for (int t = 1; t <= 10 && lat < 0; t++) begin
                    tick();
                    if (Done === 1'b1) begin
                        lat = t;
                        busy_at_done = Busy;
                    end
                end
            end else begin
                repeat (HALF - 5) tick();
            end
        end
    endtask

    // Full transfer with checks against the reference model
    task automatic run_frame(input logic [7:0] b, input bit ack, input int inject_at, input string tag);
        logic [10:0] bits;
        int d2, d3, lat, bl;
        logic bad;
        int dc0, ec0;
        dc0 = done_cnt;
        ec0 = err_cnt;
        oe_after_err = 2'b11;
        start_tx(b, tag);
        dev_frame(ack, inject_at, -1, bits, d2, d3, lat, bl, bad);
        check({tag, "_bits"}, 32'(bits), 32'(frame_model(b, ack)));
        check({tag, "_start_hold"}, 32'(d2), 32'd0);
        check({tag, "_bit0_at_3"}, 32'(d3), 32'(b[0]));
        check({tag, "_busy_thru"}, 32'(bl), 32'd0);
        if (ack) begin
            check({tag, "_done_cnt"}, 32'(done_cnt - dc0), 32'd1);
            check({tag, "_err_cnt"}, 32'(err_cnt - ec0), 32'd0);
            check({tag, "_done_lat"}, 32'(lat), 32'd3);
            check({tag, "_busy_at_done"}, {31'd0, bad}, 32'd0);
        end else begin
            check({tag, "_err_cnt"}, 32'(err_cnt - ec0), 32'd1);
            check({tag, "_done_cnt"}, 32'(done_cnt - dc0), 32'd0);
            check({tag, "_oe_after_err"}, {30'd0, oe_after_err}, 32'd0);
        end
        repeat (20) tick();
    endtask

    initial begin
        logic [10:0] bits;
        int d2, d3, lat, bl, j, dc0, ec0;
        logic bad;
        Reset = 1'b1; TxStart = 1'b0; TxData = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {26'd0, Busy, Done, Error, RxInhibit, psClkOe, psDataOe}, 32'd0);
        Reset = 1'b0;
        repeat (5) tick();

        // Directed command bytes and parity corners
        run_frame(PS2_CMD_SET_LEDS, 1'b1, -1, "t1_ed");
        run_frame(8'h01, 1'b1, -1, "t2_01");
        run_frame(PS2_CMD_RESET, 1'b1, -1, "t2_ff");
        // Missing ACK
        run_frame(8'($urandom_range(255)), 1'b0, -1, "t3_noack");
        // TxStart while busy is ignored
        run_frame(PS2_CMD_SET_LEDS, 1'b1, 4, "t4_inject");
        // Random bytes
        for (int r = 0; r < 4; r++) run_frame(8'($urandom_range(255)), 1'b1, -1, "rand");

        // Reset during bit 4, then a normal transfer
        dc0 = done_cnt; ec0 = err_cnt;
        start_tx(8'hC3, "t5_abort");
        dev_frame(1'b1, -1, 4, bits, d2, d3, lat, bl, bad);
        check("t5_no_pulses", 32'((done_cnt - dc0) + (err_cnt - ec0)), 32'd0);
        repeat (30) tick();
        run_frame(PS2_CMD_ENABLE, 1'b1, -1, "t5_f4");

        // Device never clocks
        ec0 = err_cnt;
        start_tx(8'($urandom_range(255)), "t6");
        for (j = 1; j <= 2500; j++) begin
            tick();
            if (Error === 1'b1) break;
        end
`ifdef PS2_TX_TIMEOUT_EN
        check("t6_timeout_at", 32'(j), 32'(TMO));
        check("t6_lines_released", {30'd0, psClkOe, psDataOe}, 32'd0);
        tick();
        check("t6_busy_after", {31'd0, Busy}, 32'd0);
`else
        check("t6_no_timeout", 32'(err_cnt - ec0), 32'd0);
        check("t6_still_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t6_reset_release", {29'd0, Busy, psClkOe, psDataOe}, 32'd0);
`endif

        check("done_error_exclusive", 32'(both_cnt), 32'd0);
        check("rxinhibit_eq_busy", 32'(rxinh_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
